gb_bus_trace: RTL and testbench
===============================

GB_BUS_TRACE -- requirements
Module: gb_bus_trace

Interface
REQ-001 The module SHALL have parameter DEPTH, default 16, setting the FIFO depth in records; the value SHALL be a power of two, minimum 4.
REQ-002 The module SHALL have parameter TS_WIDTH, default 22, setting the timestamp width in bits.
REQ-003 Port clk, input, 1 bit: the single clock; every register SHALL be clocked on its rising edge.
REQ-004 Port n_reset, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port tick, input, 1 bit: one-cycle pulse per GameBoy clock rising edge, supplied by the clock generator.
REQ-006 Port enable, input, 1 bit: gates both timestamp counting and capture.
REQ-007 Port clear, input, 1 bit: synchronous flush of the FIFO, timestamp and drop count.
REQ-008 Port adr, input, 15 bits: registered address bus A0-A14.
REQ-009 Port n_cs, input, 1 bit: registered A15 / ROM select.
REQ-010 Port n_read, input, 1 bit: registered read strobe, active low.
REQ-011 Port n_write, input, 1 bit: registered write strobe, active low.
REQ-012 Port data_in, input, 8 bits: registered data bus.
REQ-013 Port out_valid, output, 1 bit: the FIFO head is valid.
REQ-014 Port out_ready, input, 1 bit: the consumer accepts the head.
REQ-015 Port out_data, output, 2+TS_WIDTH+24 bits: record {kind[1:0], ts, addr[15:0], data[7:0]}.
REQ-016 Port level, output, log2(DEPTH)+1 bits: FIFO occupancy.
REQ-017 Port drop_cnt, output, 8 bits: pending dropped-record count.

Function
REQ-018 The timestamp counter SHALL increment by 1 on each tick while enable=1, and SHALL wrap modulo 2^TS_WIDTH.
REQ-019 A strobe cycle SHALL start on the first cycle where n_read or n_write is sampled low after being high, while enable=1.
- At start, ts_start SHALL latch the current timestamp.
- The strobe kind SHALL be latched: read=01, write=10.
REQ-020 If n_read and n_write both go low in the same start cycle, no cycle SHALL be started.
REQ-021 While the strobe is low, addr={n_cs, adr} and data_in SHALL be re-latched every cycle, so the values from the last low cycle are recorded.
REQ-022 A strobe cycle SHALL end on the first cycle the latched strobe is sampled high.
- The strobe SHALL have been low for at least 2 cycles, otherwise it is discarded as a glitch.
- A valid end cycle N SHALL yield a record {kind, ts_start, addr, data}.
REQ-023 Record push:
- FIFO not full at cycle N: the record SHALL be written, visible at the head in cycle N+1 if the FIFO was empty (first-word fall-through).
- FIFO full: the record SHALL be dropped and drop_cnt SHALL increment, saturating at 255.
REQ-024 Fullness SHALL use the registered level; a pop in the same cycle SHALL NOT make room for a push.
REQ-025 While drop_cnt>0 and the FIFO is not full, the block SHALL write a marker {11, current ts, 16'h0000, drop_cnt} and clear drop_cnt, before any further record.
- A record ending in the same cycle as a marker write SHALL be dropped, and drop_cnt SHALL become 1.
REQ-026 Pop SHALL occur when out_valid && out_ready.
- Simultaneous push and pop on a non-full FIFO SHALL leave level unchanged.
REQ-027 out_data SHALL be all-zero whenever out_valid=0.
REQ-028 clear=1 SHALL empty the FIFO, zero ts and drop_cnt, and abort any open strobe cycle, all in one cycle; clear SHALL take priority over push and pop.
REQ-029 Deasserting enable mid-strobe SHALL abort that cycle without creating a record.

Reset
REQ-030 With n_reset=0 at a clk edge, all state SHALL reset: out_valid=0, out_data=0, level=0, drop_cnt=0, ts=0, no open strobe cycle.
REQ-031 Reset SHALL dominate clear, enable and out_ready.
REQ-032 Strobes already low when n_reset releases SHALL NOT be recorded until they have been seen high.

Configuration
REQ-033 With macro GB_TRACE_FILTER_EN defined, the module SHALL add inputs filt_lo[15:0] and filt_hi[15:0].
- Only records with filt_lo<=addr<=filt_hi SHALL be pushed.
- Filtered-out records SHALL NOT count as drops.
- Markers SHALL be unaffected by the filter.
REQ-034 Without GB_TRACE_FILTER_EN, these ports SHALL NOT exist and every valid record SHALL be pushed.

Verification
REQ-035 Reset, then hold enable=1 with ts=5 and a read strobe low 4 cycles at adr=0x100, n_cs=0, data=0xC3 -> one record: kind=01, ts=5, addr=0x0100, data=0xC3; level=1.
REQ-036 Write strobe low 1 cycle -> no record, level stays 0; the same strobe low 2 cycles at adr=0x7FFF, n_cs=1 -> record with kind=10, addr=0xFFFF.
REQ-037 out_ready=0, DEPTH+3 reads -> level=DEPTH, drop_cnt=3; then pop one -> next cycle a marker {11, ts, 0x0000, 0x03} is written and drop_cnt=0.
REQ-038 Full FIFO with a push and pop in the same cycle -> the pushed record is dropped, drop_cnt=1, level=DEPTH-1.
REQ-039 clear=1 during an open strobe while level=5 -> level=0, ts=0, no record when the strobe ends.
REQ-040 With GB_TRACE_FILTER_EN, filt=0x0100..0x014F, reads at 0x00FF, 0x0100 and 0x0150 -> exactly one record (0x0100) and drop_cnt=0.

Source files
------------

// File: rtl/gb_bus_trace.sv
`default_nettype none
// ============================================================================
// Module   : gb_bus_trace
// Purpose  : GameBoy cartridge bus tracer. Detects read/write strobe cycles,
//            timestamps them and queues {kind, ts, addr, data} records in a
//            first-word-fall-through FIFO, with drop counting and overflow
//            marker records.
// Options  : define GB_TRACE_FILTER_EN to add an address-window filter
//            (filt_lo/filt_hi ports).
// Revision : 1.0 - initial release
// ============================================================================
module gb_bus_trace #(
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 22
) (
  input  logic                          clk,
  input  logic                          n_reset,
  input  logic                          tick,
  input  logic                          enable,
  input  logic                          clear,
  input  logic [14:0]                   adr,
  input  logic                          n_cs,
  input  logic                          n_read,
  input  logic                          n_write,
  input  logic [7:0]                    data_in,
`ifdef GB_TRACE_FILTER_EN
  input  logic [15:0]                   filt_lo,
  input  logic [15:0]                   filt_hi,
`endif
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [2+TS_WIDTH+24-1:0]      out_data,
  output logic [$clog2(DEPTH):0]        level,
  output logic [7:0]                    drop_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = 2 + TS_WIDTH + 24;
  localparam logic [1:0]  KIND_READ  = 2'b01;
  localparam logic [1:0]  KIND_WRITE = 2'b10;
  localparam logic [1:0]  KIND_MARK  = 2'b11;
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  // Reject depths the pointer arithmetic cannot support.
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("gb_bus_trace: DEPTH must be a power of two >= 4");
  end

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [TS_WIDTH-1:0]   ts;
  logic                  rd_prev, wr_prev;
  logic [1:0]            kind;
  logic [TS_WIDTH-1:0]   ts_start;
  logic [15:0]           addr;
  logic [7:0]            data;
  logic                  held;        // strobe seen low on a second cycle
  logic [REC_W-1:0]      mem [DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic [AW:0]           level_q;
  logic [7:0]            drop_q;

  logic rd_fall, wr_fall, strobe_hi;
  logic start, relatch, rec_end;
  logic rec_pass, rec_req, full, mark_wr, rec_wr, push, pop;
  logic [REC_W-1:0] push_data;

  assign rd_fall   = rd_prev & ~n_read;
  assign wr_fall   = wr_prev & ~n_write;
  assign strobe_hi = (kind == KIND_READ) ? n_read : n_write;

  // Strobe-cycle FSM: next state and per-cycle capture controls.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    relatch   = 1'b0;
    rec_end   = 1'b0;
    case (state)
      S_IDLE: begin
        // Both strobes falling together is ambiguous, so it starts nothing.
        if (enable && (rd_fall ^ wr_fall)) begin
          start     = 1'b1;
          state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (!enable) begin
          state_nxt = S_IDLE;
        end else if (strobe_hi) begin
          state_nxt = S_IDLE;
          rec_end   = held;
        end else begin
          relatch = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (clear) begin
      state_nxt = S_IDLE;
      start     = 1'b0;
      relatch   = 1'b0;
      rec_end   = 1'b0;
    end
  end

`ifdef GB_TRACE_FILTER_EN
  assign rec_pass = (addr >= filt_lo) && (addr <= filt_hi);
`else
  assign rec_pass = 1'b1;
`endif

  // Fullness comes from the registered level, so a same-cycle pop never
  // frees a slot for a push. A pending marker always wins over a record.
  assign rec_req   = rec_end & rec_pass;
  assign full      = (level_q == FULL_LEVEL);
  assign mark_wr   = !clear && (drop_q != 8'd0) && !full;
  assign rec_wr    = rec_req && !full && !mark_wr;
  assign push      = mark_wr | rec_wr;
  assign out_valid = (level_q != '0);
  assign pop       = out_valid & out_ready & ~clear;
  assign push_data = mark_wr ? {KIND_MARK, ts, 16'h0000, drop_q}
                             : {kind, ts_start, addr, data};

  assign out_data  = out_valid ? mem[rptr] : '0;
  assign level     = level_q;
  assign drop_cnt  = drop_q;

  // State register, strobe history and timestamp.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state   <= S_IDLE;
      ts      <= '0;
      rd_prev <= 1'b0;   // strobes low at reset release must be seen high first
      wr_prev <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_prev <= n_read;
      wr_prev <= n_write;
      if (clear)
        ts <= '0;
      else if (enable && tick)
        ts <= ts + 1'b1;
    end
  end

  // Strobe-cycle capture: kind and start time at the falling edge, bus
  // values on every low cycle so the last low cycle is what gets recorded.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      kind     <= 2'b00;
      ts_start <= '0;
      addr     <= 16'h0000;
      data     <= 8'h00;
      held     <= 1'b0;
    end else if (start) begin
      kind     <= rd_fall ? KIND_READ : KIND_WRITE;
      ts_start <= ts;
      addr     <= {n_cs, adr};
      data     <= data_in;
      held     <= 1'b0;
    end else if (relatch) begin
      addr     <= {n_cs, adr};
      data     <= data_in;
      held     <= 1'b1;
    end
  end

  // FIFO pointers, occupancy and drop counter.
  always_ff @(posedge clk) begin
    if (!n_reset || clear) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
      drop_q  <= 8'd0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (mark_wr)
        drop_q <= rec_req ? 8'd1 : 8'd0;
      else if (rec_req && full && (drop_q != 8'hFF))
        drop_q <= drop_q + 8'd1;
    end
  end

  // FIFO storage; contents are only meaningful below the level, so no reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_gb_bus_trace.sv
`default_nettype none
// ============================================================================
// Module   : tb_gb_bus_trace
// Purpose  : Directed self-checking bench for gb_bus_trace (defaults:
//            DEPTH=16, TS_WIDTH=22). Filter scenario runs when
//            GB_TRACE_FILTER_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gb_bus_trace;

  localparam int DEPTH = 16;
  localparam int TS_W  = 22;
  localparam int REC_W = 2 + TS_W + 24;

  logic              clk = 1'b0;
  logic              n_reset, tick, enable, clear;
  logic [14:0]       adr;
  logic              n_cs, n_read, n_write;
  logic [7:0]        data_in;
  logic              out_ready, out_valid;
  logic [REC_W-1:0]  out_data;
  logic [4:0]        level;
  logic [7:0]        drop_cnt;
`ifdef GB_TRACE_FILTER_EN
  logic [15:0]       filt_lo, filt_hi;
`endif

  int vectors     = 0;
  int miscompares = 0;

  gb_bus_trace #(.DEPTH(DEPTH), .TS_WIDTH(TS_W)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .tick      (tick),
    .enable    (enable),
    .clear     (clear),
    .adr       (adr),
    .n_cs      (n_cs),
    .n_read    (n_read),
    .n_write   (n_write),
    .data_in   (data_in),
`ifdef GB_TRACE_FILTER_EN
    .filt_lo   (filt_lo),
    .filt_hi   (filt_hi),
`endif
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .level     (level),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [REC_W-1:0] rec(input logic [1:0] k, input logic [TS_W-1:0] t,
                                           input logic [15:0] a, input logic [7:0] d);
    return {k, t, a, d};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One strobe: bus set up, strobe low for 'low' cycles, then released.
  task automatic strobe(input bit wr, input logic [14:0] a, input logic cs,
                        input logic [7:0] d, input int low);
    adr = a; n_cs = cs; data_in = d;
    if (wr) n_write = 1'b0; else n_read = 1'b0;
    step(low);
    n_read = 1'b1; n_write = 1'b1;
    step(1);
  endtask

  task automatic do_clear();
    clear = 1'b1; step(1); clear = 1'b0;
  endtask

  task automatic test_reset();
    n_reset = 1'b0; clear = 1'b1; enable = 1'b1; out_ready = 1'b1; tick = 1'b1;
    n_read = 1'b1; n_write = 1'b1; adr = '0; n_cs = 1'b0; data_in = '0;
    step(2);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", out_data); end
    vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL reset_level: got %0d expected 0", level); end
    vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
    n_reset = 1'b1; clear = 1'b0; enable = 1'b0; out_ready = 1'b0; tick = 1'b0;
    step(1);
  endtask

  task automatic test_stale_strobe();
    n_reset = 1'b0; n_read = 1'b0; enable = 1'b1;
    step(2);
    n_reset = 1'b1;
    step(3);
    n_read = 1'b1;
    step(2);
    vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL stale_level: got %0d expected 0", level); end
  endtask

  task automatic test_read_record();
    do_clear();
    enable = 1'b1; tick = 1'b1; step(5); tick = 1'b0;
    strobe(1'b0, 15'h0100, 1'b0, 8'hC3, 4);
    vectors++; if (level !== 5'd1) begin miscompares++; $display("FAIL read_level: got %0d expected 1", level); end
    vectors++; if (out_data !== rec(2'b01, 22'd5, 16'h0100, 8'hC3)) begin miscompares++; $display("FAIL read_data: got %h expected %h", out_data, rec(2'b01, 22'd5, 16'h0100, 8'hC3)); end
    out_ready = 1'b1; step(1); out_ready = 1'b0;
    vectors++; if (out_data !== '0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL read_pop: got valid %b data %h expected 0/0", out_valid, out_data); end
  endtask

  task automatic test_glitch_and_write();
    do_clear();
    tick = 1'b1; step(2); tick = 1'b0;
    strobe(1'b1, 15'h0000, 1'b0, 8'h00, 1);
    vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL glitch_level: got %0d expected 0", level); end
    strobe(1'b1, 15'h7FFF, 1'b1, 8'h5A, 2);
    vectors++; if (out_data !== rec(2'b10, 22'd2, 16'hFFFF, 8'h5A)) begin miscompares++; $display("FAIL write_data: got %h expected %h", out_data, rec(2'b10, 22'd2, 16'hFFFF, 8'h5A)); end
    // Record ending on the same edge as a pop: level holds at 1.
    adr = 15'h0010; n_cs = 1'b0; data_in = 8'h11; n_read = 1'b0;
    step(2);
    n_read = 1'b1; out_ready = 1'b1; step(1); out_ready = 1'b0;
    vectors++; if (level !== 5'd1) begin miscompares++; $display("FAIL b2b_level: got %0d expected 1", level); end
    vectors++; if (out_data !== rec(2'b01, 22'd2, 16'h0010, 8'h11)) begin miscompares++; $display("FAIL b2b_data: got %h expected %h", out_data, rec(2'b01, 22'd2, 16'h0010, 8'h11)); end
    do_clear();
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 1; i <= DEPTH + 3; i++)
      strobe(1'b0, 15'(i), 1'b0, 8'(i), 2);
    vectors++; if (level !== 5'd16) begin miscompares++; $display("FAIL ovf_level: got %0d expected 16", level); end
    vectors++; if (drop_cnt !== 8'd3) begin miscompares++; $display("FAIL ovf_drop: got %0d expected 3", drop_cnt); end
    vectors++; if (out_data !== rec(2'b01, 22'd0, 16'h0001, 8'h01)) begin miscompares++; $display("FAIL ovf_head: got %h expected %h", out_data, rec(2'b01, 22'd0, 16'h0001, 8'h01)); end
    out_ready = 1'b1; step(1); out_ready = 1'b0;
    vectors++; if (level !== 5'd15 || drop_cnt !== 8'd3) begin miscompares++; $display("FAIL ovf_pop: got level %0d drop %0d expected 15/3", level, drop_cnt); end
    step(1);
    vectors++; if (level !== 5'd16 || drop_cnt !== 8'd0) begin miscompares++; $display("FAIL ovf_marker: got level %0d drop %0d expected 16/0", level, drop_cnt); end
    out_ready = 1'b1; step(15); out_ready = 1'b0;
    vectors++; if (out_data !== rec(2'b11, 22'd0, 16'h0000, 8'h03)) begin miscompares++; $display("FAIL ovf_marker_data: got %h expected %h", out_data, rec(2'b11, 22'd0, 16'h0000, 8'h03)); end
    vectors++; if (level !== 5'd1) begin miscompares++; $display("FAIL ovf_drain: got %0d expected 1", level); end
    do_clear();
  endtask

  task automatic test_full_push_pop();
    do_clear();
    for (int i = 0; i < DEPTH; i++)
      strobe(1'b0, 15'(i), 1'b0, 8'(i), 2);
    adr = 15'h0033; data_in = 8'h33; n_read = 1'b0;
    step(2);
    n_read = 1'b1; out_ready = 1'b1; step(1); out_ready = 1'b0;
    vectors++; if (level !== 5'd15 || drop_cnt !== 8'd1) begin miscompares++; $display("FAIL fullpp: got level %0d drop %0d expected 15/1", level, drop_cnt); end
    step(1);
    vectors++; if (level !== 5'd16 || drop_cnt !== 8'd0) begin miscompares++; $display("FAIL fullpp_marker: got level %0d drop %0d expected 16/0", level, drop_cnt); end
    do_clear();
  endtask

  task automatic test_clear_abort();
    do_clear();
    tick = 1'b1; step(3); tick = 1'b0;
    for (int i = 0; i < 5; i++)
      strobe(1'b1, 15'(i + 8), 1'b0, 8'(i), 2);
    vectors++; if (level !== 5'd5) begin miscompares++; $display("FAIL clr_fill: got %0d expected 5", level); end
    n_read = 1'b0; step(2);
    clear = 1'b1; step(1); clear = 1'b0;
    vectors++; if (level !== 5'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL clr_level: got level %0d valid %b expected 0/0", level, out_valid); end
    step(1);
    n_read = 1'b1; step(2);
    vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL clr_abort: got %0d expected 0", level); end
    strobe(1'b0, 15'h0042, 1'b0, 8'h99, 2);
    vectors++; if (out_data !== rec(2'b01, 22'd0, 16'h0042, 8'h99)) begin miscompares++; $display("FAIL clr_ts: got %h expected %h", out_data, rec(2'b01, 22'd0, 16'h0042, 8'h99)); end
    do_clear();
  endtask

  task automatic test_enable_abort();
    enable = 1'b1;
    n_read = 1'b0; step(2);
    enable = 1'b0; step(1);
    enable = 1'b1; n_read = 1'b1; step(2);
    vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL en_abort: got %0d expected 0", level); end
  endtask

`ifdef GB_TRACE_FILTER_EN
  task automatic test_filter();
    do_clear();
    filt_lo = 16'h0100; filt_hi = 16'h014F;
    strobe(1'b0, 15'h00FF, 1'b0, 8'hA1, 2);
    strobe(1'b0, 15'h0100, 1'b0, 8'hA2, 2);
    strobe(1'b0, 15'h0150, 1'b0, 8'hA3, 2);
    vectors++; if (level !== 5'd1 || drop_cnt !== 8'd0) begin miscompares++; $display("FAIL filt_level: got level %0d drop %0d expected 1/0", level, drop_cnt); end
    vectors++; if (out_data !== rec(2'b01, 22'd0, 16'h0100, 8'hA2)) begin miscompares++; $display("FAIL filt_data: got %h expected %h", out_data, rec(2'b01, 22'd0, 16'h0100, 8'hA2)); end
    do_clear();
  endtask
`endif

  initial begin
`ifdef GB_TRACE_FILTER_EN
    filt_lo = 16'h0000; filt_hi = 16'hFFFF;
`endif
    test_reset();
    test_stale_strobe();
    test_read_record();
    test_glitch_and_write();
    test_overflow();
    test_full_push_pop();
    test_clear_abort();
    test_enable_abort();
`ifdef GB_TRACE_FILTER_EN
    test_filter();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
